// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake and a synchronous flush.
// SKID=1 holds two entries and drives in_ready from a register. SKID=0 holds a single entry.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        count
);

   logic              push, pop, head_vld;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] head_ctrl;

   assign push      = in_valid & in_ready;
   assign pop       = head_vld & out_ready;
   assign out_valid = head_vld;
   assign out_data  = head_data;
   // A bubble must never leak control enables downstream.
   assign out_ctrl  = head_vld ? head_ctrl : '0;

   generate
      if (SKID != 0) begin : g_skid
         typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
         state_t            state, state_n;
         logic              rdy_q, ld_in, ld_from_skid, ld_skid;
         logic [DATA_W-1:0] skid_data;
         logic [CTRL_W-1:0] skid_ctrl;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state     <= EMPTY;
               rdy_q     <= 1'b1;
               head_data <= '0;
               head_ctrl <= '0;
               skid_data <= '0;
               skid_ctrl <= '0;
            end else begin
               state <= state_n;
               rdy_q <= (state_n != TWO);
               if (flush) begin
                  head_data <= '0;
                  head_ctrl <= '0;
                  skid_data <= '0;
                  skid_ctrl <= '0;
               end else begin
                  if (ld_in) begin
                     head_data <= in_data;
                     head_ctrl <= in_ctrl;
                  end else if (ld_from_skid) begin
                     head_data <= skid_data;
                     head_ctrl <= skid_ctrl;
                  end
                  if (ld_skid) begin
                     skid_data <= in_data;
                     skid_ctrl <= in_ctrl;
                  end
               end
            end
         end

         always_comb begin
            state_n      = state;
            ld_in        = 1'b0;
            ld_from_skid = 1'b0;
            ld_skid      = 1'b0;
            if (flush) begin
               state_n = EMPTY;
            end else begin
               case (state)
                  EMPTY: if (push) begin
                     state_n = ONE;
                     ld_in   = 1'b1;
                  end
                  ONE: begin
                     if (push && !pop) begin
                        state_n = TWO;
                        ld_skid = 1'b1;
                     end else if (!push && pop) begin
                        state_n = EMPTY;
                     end else if (push && pop) begin
                        ld_in = 1'b1;
                     end
                  end
                  TWO: if (pop) begin
                     state_n      = ONE;
                     ld_from_skid = 1'b1;
                  end
                  default: state_n = EMPTY;
               endcase
            end
         end

         // The ready path is cut here: in_ready never sees out_ready in the same cycle.
         assign in_ready = rdy_q;
         assign head_vld = (state != EMPTY);
         assign count    = state;
      end else begin : g_single
         logic vld_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q     <= 1'b0;
               head_data <= '0;
               head_ctrl <= '0;
            end else if (flush) begin
               vld_q     <= 1'b0;
               head_data <= '0;
               head_ctrl <= '0;
            end else if (push) begin
               vld_q     <= 1'b1;
               head_data <= in_data;
               head_ctrl <= in_ctrl;
            end else if (pop) begin
               vld_q <= 1'b0;
            end
         end

         assign in_ready = !vld_q | out_ready;
         assign head_vld = vld_q;
         assign count    = {1'b0, vld_q};
      end
   endgenerate

endmodule
